// File: rtl/operand_capture.sv
// Captures debounced BCD operands from the entry bus into a small bank of slots.
// The write pointer auto-advances; a full bank either wraps or refuses writes.
module operand_capture #(
  parameter int DIGITS          = 4,
  parameter int SLOTS           = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int WRAP            = 1,
  parameter int PW              = $clog2(SLOTS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      button,
  input  logic                      clear,
  input  logic [4*DIGITS-1:0]       digits_in,
  input  logic [PW-1:0]             rd_sel,
  output logic [4*DIGITS-1:0]       rd_data,
  output logic [4*DIGITS*SLOTS-1:0] operands,
  output logic [SLOTS-1:0]          slot_valid,
  output logic [PW-1:0]             wr_ptr,
  output logic                      full,
  output logic                      capture_pulse,
  output logic                      bcd_error,
  output logic                      overflow
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(SLOTS - 1);
  localparam logic [PW:0]   SLOTS_W  = (PW + 1)'(SLOTS);

  logic          s1_q, s2_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press;

  logic [W-1:0]     ops_q [SLOTS];
  logic [W-1:0]     ops_d [SLOTS];
  logic [SLOTS-1:0] valid_q, valid_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             cap_q, cap_d;
  logic             bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             bcd_ok;

  // A press is the edge on which the debounced level commits 0->1.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    press = 1'b0;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = s2_q;
        press = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    bcd_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits_in[4*i +: 4] > 4'd9) bcd_ok = 1'b0;
    end
  end

  always_comb begin
    ops_d   = ops_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    cap_d   = 1'b0;
    bcd_d   = 1'b0;
    ovf_d   = 1'b0;
    if (clear) begin
      for (int k = 0; k < SLOTS; k++) ops_d[k] = '0;
      valid_d = '0;
      ptr_d   = '0;
    end else if (press) begin
      if (!bcd_ok) begin
        bcd_d = 1'b1;
      end else if (full && (WRAP == 0)) begin
        ovf_d = 1'b1;
      end else begin
        ops_d[ptr_q]   = digits_in;
        valid_d[ptr_q] = 1'b1;
        ptr_d          = (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
        cap_d          = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
      for (int k = 0; k < SLOTS; k++) ops_q[k] <= '0;
      valid_q <= '0;
      ptr_q   <= '0;
      cap_q   <= 1'b0;
      bcd_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      s1_q    <= button;
      s2_q    <= s1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      ops_q   <= ops_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cap_q   <= cap_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  for (genvar k = 0; k < SLOTS; k++) begin : g_flat
    assign operands[W*k +: W] = ops_q[k];
  end

  // Unused select codes exist when SLOTS is not a power of two.
  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_sel} < SLOTS_W) rd_data = ops_q[rd_sel];
  end

  assign slot_valid    = valid_q;
  assign wr_ptr        = ptr_q;
  assign full          = &valid_q;
  assign capture_pulse = cap_q;
  assign bcd_error     = bcd_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_operand_capture.sv
// Bench for operand_capture: one wrapping and one refusing instance share stimulus
// and are checked every cycle against a sliding-window press/slot model.
module tb_operand_capture;
  localparam int D = 4;

  logic        clk = 1'b0, reset = 1'b1, button = 1'b0, clear = 1'b0;
  logic [15:0] digits_in = '0;
  logic        rd_sel = 1'b0;

  logic [15:0] rd1, rd0;
  logic [31:0] ops1, ops0;
  logic [1:0]  val1, val0;
  logic        ptr1, ptr0, full1, full0, cap1, cap0, bcd1, bcd0, ovf1, ovf0;

  int n_cmp = 0, n_bad = 0;
  int cap_seen1 = 0, ovf_seen0 = 0, ovf_seen1 = 0, bcd_seen1 = 0;

  operand_capture #(.DIGITS(4), .SLOTS(2), .DEBOUNCE_CYCLES(D), .WRAP(1)) u1 (
    .clk(clk), .reset(reset), .button(button), .clear(clear), .digits_in(digits_in),
    .rd_sel(rd_sel), .rd_data(rd1), .operands(ops1), .slot_valid(val1), .wr_ptr(ptr1),
    .full(full1), .capture_pulse(cap1), .bcd_error(bcd1), .overflow(ovf1));

  operand_capture #(.DIGITS(4), .SLOTS(2), .DEBOUNCE_CYCLES(D), .WRAP(0)) u0 (
    .clk(clk), .reset(reset), .button(button), .clear(clear), .digits_in(digits_in),
    .rd_sel(rd_sel), .rd_data(rd0), .operands(ops0), .slot_valid(val0), .wr_ptr(ptr0),
    .full(full0), .capture_pulse(cap0), .bcd_error(bcd0), .overflow(ovf0));

  initial forever #5 clk = ~clk;
  initial forever begin
    @(negedge clk);
    #2 rd_sel = ~rd_sel;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the debounced level flips once the last D synchronised samples all
  // disagree with it; a flip to 1 is a press. Index 0 = refusing, 1 = wrapping.
  bit          hist [0:D];
  bit          mdb, all_v, rise, bad;
  logic [15:0] mslot [2][2];
  logic [1:0]  mvalid [2];
  int          mptr [2];
  bit          mcap [2], mbcd [2], movf [2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j <= D; j++) hist[j] = 1'b0;
      mdb = 1'b0;
      for (int w = 0; w < 2; w++) begin
        mslot[w][0] = '0; mslot[w][1] = '0; mvalid[w] = '0; mptr[w] = 0;
        mcap[w] = 1'b0; mbcd[w] = 1'b0; movf[w] = 1'b0;
      end
    end else begin
      all_v = 1'b1;
      for (int j = 1; j <= D; j++) if (hist[j] == mdb) all_v = 1'b0;
      rise = 1'b0;
      if (all_v) begin
        mdb  = !mdb;
        rise = mdb;
      end
      for (int j = D; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = button;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) if (digits_in[4*i +: 4] > 4'd9) bad = 1'b1;
      for (int w = 0; w < 2; w++) begin
        mcap[w] = 1'b0; mbcd[w] = 1'b0; movf[w] = 1'b0;
        if (clear) begin
          mslot[w][0] = '0; mslot[w][1] = '0; mvalid[w] = '0; mptr[w] = 0;
        end else if (rise) begin
          if (bad) mbcd[w] = 1'b1;
          else if (mvalid[w] == 2'b11 && w == 0) movf[w] = 1'b1;
          else begin
            mslot[w][mptr[w]]  = digits_in;
            mvalid[w][mptr[w]] = 1'b1;
            mptr[w]            = (mptr[w] + 1) % 2;
            mcap[w]            = 1'b1;
          end
        end
      end
    end
  end

  task automatic cmp_inst(input int w, input logic [31:0] ops, input logic [1:0] val,
                          input logic ptr, input logic fl, input logic cap,
                          input logic bcd, input logic ovf, input logic [15:0] rd);
    string p;
    p = (w == 1) ? "wrap1" : "wrap0";
    check({p, ".operands"},   ops, {mslot[w][1], mslot[w][0]});
    check({p, ".slot_valid"}, {30'b0, val}, {30'b0, mvalid[w]});
    check({p, ".wr_ptr"},     {31'b0, ptr}, mptr[w]);
    check({p, ".full"},       {31'b0, fl}, {31'b0, mvalid[w] == 2'b11});
    check({p, ".capture"},    {31'b0, cap}, {31'b0, mcap[w]});
    check({p, ".bcd_error"},  {31'b0, bcd}, {31'b0, mbcd[w]});
    check({p, ".overflow"},   {31'b0, ovf}, {31'b0, movf[w]});
    check({p, ".rd_data"},    {16'b0, rd}, {16'b0, mslot[w][rd_sel]});
    check({p, ".pulse_excl"}, {31'b0, $onehot0({cap, bcd, ovf})}, 32'd1);
  endtask

  always @(negedge clk) begin
    cmp_inst(0, ops0, val0, ptr0, full0, cap0, bcd0, ovf0, rd0);
    cmp_inst(1, ops1, val1, ptr1, full1, cap1, bcd1, ovf1, rd1);
    if (cap1) cap_seen1++;
    if (bcd1) bcd_seen1++;
    if (ovf0) ovf_seen0++;
    if (ovf1) ovf_seen1++;
  end

  task automatic press(input logic [15:0] v);
    digits_in = v;
    button    = 1'b1;
    repeat (D + 4) @(negedge clk);
    button    = 1'b0;
    repeat (D + 4) @(negedge clk);
  endtask

  int c0, o0, o1, b0;

  initial begin
    repeat (2) @(negedge clk);
    check("reset_valid", {30'b0, val1}, 32'd0);
    check("reset_ops", ops1, 32'd0);

    // Latency from reset release with the button already high.
    digits_in = 16'h1234;
    button    = 1'b1;
    reset     = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("lat_early", {31'b0, cap1}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("lat_pulse", {31'b0, cap1}, 32'd1);
    check("lat_slot0", ops1, 32'h0000_1234);
    check("lat_valid", {30'b0, val1}, 32'd1);
    check("lat_ptr", {31'b0, ptr1}, 32'd1);
    button = 1'b0;
    repeat (10) @(negedge clk);

    // Short glitch.
    c0 = cap_seen1;
    button = 1'b1;
    repeat (3) @(negedge clk);
    button = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_nocap", cap_seen1 - c0, 32'd0);
    check("glitch_valid", {30'b0, val1}, 32'd1);

    // Three presses into an empty bank.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_ops", ops1, 32'd0);
    o0 = ovf_seen0; o1 = ovf_seen1;
    press(16'h1234);
    press(16'h5678);
    press(16'h0999);
    check("wrap1_ops", ops1, 32'h5678_0999);
    check("wrap1_valid", {30'b0, val1}, 32'd3);
    check("wrap1_ptr", {31'b0, ptr1}, 32'd1);
    check("wrap1_full", {31'b0, full1}, 32'd1);
    check("wrap1_noovf", ovf_seen1 - o1, 32'd0);
    check("wrap0_ops", ops0, 32'h5678_1234);
    check("wrap0_ptr", {31'b0, ptr0}, 32'd0);
    check("wrap0_ovf", ovf_seen0 - o0, 32'd1);

    // Invalid digit then a valid one.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    b0 = bcd_seen1;
    press(16'h12A4);
    check("bcd_pulse", bcd_seen1 - b0, 32'd1);
    check("bcd_valid", {30'b0, val1}, 32'd0);
    check("bcd_ptr", {31'b0, ptr1}, 32'd0);
    press(16'h0042);
    check("after_bcd_ops", ops1, 32'h0000_0042);
    check("after_bcd_valid", {30'b0, val1}, 32'd1);

    // Clear held across the capture edge.
    c0 = cap_seen1;
    clear = 1'b1;
    press(16'h4321);
    clear = 1'b0;
    check("clrcap_nocap", cap_seen1 - c0, 32'd0);
    check("clrcap_ops", ops1, 32'd0);
    check("clrcap_valid", {30'b0, val1}, 32'd0);

    // Reset mid-debounce with the button still high.
    press(16'h0077);
    check("pre_rst_valid", {30'b0, val1}, 32'd1);
    button = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_ops", ops1, 32'd0);
    check("rst_valid", {30'b0, val1}, 32'd0);
    check("rst_ptr", {31'b0, ptr1}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_lat_early", {31'b0, cap1}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_lat_pulse", {31'b0, cap1}, 32'd1);
    check("rst_lat_ops", ops1, 32'h0000_0077);
    button = 1'b0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
